// File: rtl/mul_seq_pkg.sv
// Shared definitions for the 16-bit datapath: machine word type and the
// ALU command encoding used by both the ALU and the multiply sequencer.
package mul_seq_pkg;

  localparam int WIDTH = 16;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    ALU_THA = 3'b000,
    ALU_THB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SL  = 3'b100,
    ALU_SR  = 3'b101,
    ALU_ADD = 3'b110,
    ALU_SUB = 3'b111
  } alu_cmd_e;

endpackage

// File: rtl/mul_seq_if.sv
// Request/response and ALU-borrow signals between the CPU datapath and the
// multiply sequencer.
interface mul_seq_if;
  import mul_seq_pkg::*;

  logic     start;
  word_t    op_a;
  word_t    op_b;
  logic     busy;
  logic     done;
  word_t    result;
  word_t    alu_a;
  word_t    alu_b;
  alu_cmd_e alu_com;
  word_t    alu_y;

  modport master (
    output start, op_a, op_b, alu_y,
    input  busy, done, result, alu_a, alu_b, alu_com
  );

  modport slave (
    input  start, op_a, op_b, alu_y,
    output busy, done, result, alu_a, alu_b, alu_com
  );

endinterface

// File: rtl/alu.sv
// Shared 16-bit combinational ALU; shifts move by one bit, arithmetic wraps
// modulo 2^16.
module alu
  import mul_seq_pkg::*;
(
  input  word_t    a,
  input  word_t    b,
  input  alu_cmd_e com,
  output word_t    y
);

  always_comb begin
    y = '0;
    case (com)
      ALU_THA: y = a;
      ALU_THB: y = b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SL:  y = a << 1;
      ALU_SR:  y = a >> 1;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mul_seq.sv
// Shift-and-add 16x16 multiplier (low 16 bits of the product) that borrows
// the shared ALU for every add and shift, stopping once the multiplier is 0.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  mul_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_e;

  state_e   state;
  word_t    a_r;
  word_t    b_r;
  word_t    p_r;
  word_t    result_r;
  word_t    alu_a_r;
  word_t    alu_b_r;
  alu_cmd_e alu_com_r;
  logic     busy_r;
  logic     done_r;

  // ALU drive is registered one state ahead, so each value is set on the
  // transition into the state that owns the ALU for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      p_r       <= '0;
      result_r  <= '0;
      alu_a_r   <= '0;
      alu_b_r   <= '0;
      alu_com_r <= ALU_THA;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      // NOTE: defaults at the top of a clocked block are safe (no latch can
      // form in a flop); later non-blocking assignments simply override them.
      alu_a_r   <= '0;
      alu_b_r   <= '0;
      alu_com_r <= ALU_THA;
      done_r    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_r    <= bus.op_a;
            b_r    <= bus.op_b;
            p_r    <= '0;
            busy_r <= 1'b1;
            state  <= S_EVAL;
          end
        end

        S_EVAL: begin
          if (b_r == '0) begin
            result_r <= p_r;
            done_r   <= 1'b1;
            state    <= S_DONE;
          end else if (b_r[0]) begin
            alu_a_r   <= p_r;
            alu_b_r   <= a_r;
            alu_com_r <= ALU_ADD;
            state     <= S_ADD;
          end else begin
            alu_a_r   <= a_r;
            alu_com_r <= ALU_SL;
            state     <= S_SHL;
          end
        end

        S_ADD: begin
          p_r       <= bus.alu_y;
          alu_a_r   <= a_r;
          alu_com_r <= ALU_SL;
          state     <= S_SHL;
        end

        S_SHL: begin
          a_r       <= bus.alu_y;
          alu_a_r   <= b_r;
          alu_com_r <= ALU_SR;
          state     <= S_SHR;
        end

        S_SHR: begin
          b_r   <= bus.alu_y;
          state <= S_EVAL;
        end

        S_DONE: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.result  = result_r;
  assign bus.alu_a   = alu_a_r;
  assign bus.alu_b   = alu_b_r;
  assign bus.alu_com = alu_com_r;

endmodule
